iord_seq: RTL and testbench

Parametrised, sequential successor to the combinational memory-address select in the multicycle datapath. It selects the memory address from PC, the live ALU result, ALUOut, or one of three exception-vector constants, and registers it. It then sequences a fixed-latency memory access with busy/done handshaking, and optionally rejects misaligned word accesses. It sits between the control unit and the memory block and replaces the bare address mux on the memory address port.

---
 rtl/iord_seq.sv | 126 ++++++++++++
 tb/tb_iord_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iord_seq.sv
// Registered memory-address select with a fixed-latency busy/done access sequencer.
// Optional misaligned-word rejection is enabled by defining IORD_ALIGN_CHECK_EN.
module iord_seq #(
    parameter int WIDTH       = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int VEC_D       = 253,
    parameter int VEC_E       = 254,
    parameter int VEC_F       = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       iordmux,
    input  logic [WIDTH-1:0] pcOut,
    input  logic [WIDTH-1:0] aluResult,
    input  logic [WIDTH-1:0] aluOutOut,
    input  logic             req,
    input  logic             word_access,
    output logic [WIDTH-1:0] iordOut,
    output logic             busy,
    output logic             done,
    output logic             sel_err,
    output logic             align_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0]      CNT_INIT = 16'(WAIT_CYCLES);
    localparam logic [WIDTH-1:0] ADDR_D   = WIDTH'(VEC_D);
    localparam logic [WIDTH-1:0] ADDR_E   = WIDTH'(VEC_E);
    localparam logic [WIDTH-1:0] ADDR_F   = WIDTH'(VEC_F);

    state_t           state, state_n;
    logic [15:0]      cnt, cnt_n;
    logic [WIDTH-1:0] addr_q, addr_n;
    logic             sel_err_q, sel_err_n;
    logic             align_err_q, align_err_n;
    logic [WIDTH-1:0] addr_sel;
    logic             sel_ok;
    logic             align_fault;

    always_comb begin
        addr_sel = '0;
        sel_ok   = 1'b1;
        case (iordmux)
            3'b000:  addr_sel = pcOut;
            3'b001:  addr_sel = aluResult;
            3'b010:  addr_sel = aluOutOut;
            3'b011:  addr_sel = ADDR_D;
            3'b100:  addr_sel = ADDR_E;
            3'b101:  addr_sel = ADDR_F;
            default: sel_ok   = 1'b0;
        endcase
    end

`ifdef IORD_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [WIDTH-1:0] a);
        return a[1:0] != 2'b00;
    endfunction

    assign align_fault = word_access && misaligned(addr_sel);
`else
    logic unused_word_access;
    assign unused_word_access = word_access;
    assign align_fault        = 1'b0;
`endif

    // Illegal select is checked before alignment so sel_err wins when both apply.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        addr_n      = addr_q;
        sel_err_n   = 1'b0;
        align_err_n = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (req) begin
                    if (!sel_ok) begin
                        sel_err_n = 1'b1;
                    end else if (align_fault) begin
                        align_err_n = 1'b1;
                    end else begin
                        addr_n  = addr_sel;
                        cnt_n   = CNT_INIT;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 16'd1) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            sel_err_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            addr_q      <= addr_n;
            sel_err_q   <= sel_err_n;
            align_err_q <= align_err_n;
        end
    end

    assign iordOut   = addr_q;
    assign busy      = (state == WAIT);
    assign done      = (state == DONE);
    assign sel_err   = sel_err_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_iord_seq.sv
// Directed bench for iord_seq: a WAIT_CYCLES=2 instance for most scenarios and a
// WAIT_CYCLES=4 instance for latency and mid-access reset.
module tb_iord_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  iordmux;
    logic [31:0] pcOut, aluResult, aluOutOut;
    logic        req, word_access;
    logic [31:0] iordOut, iordOut4;
    logic        busy, done, sel_err, align_err;
    logic        busy4, done4, sel_err4, align_err4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iord_seq #(.WIDTH(32), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .iordmux(iordmux), .pcOut(pcOut),
        .aluResult(aluResult), .aluOutOut(aluOutOut), .req(req),
        .word_access(word_access), .iordOut(iordOut), .busy(busy),
        .done(done), .sel_err(sel_err), .align_err(align_err)
    );

    iord_seq #(.WIDTH(32), .WAIT_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .iordmux(iordmux), .pcOut(pcOut),
        .aluResult(aluResult), .aluOutOut(aluOutOut), .req(req),
        .word_access(word_access), .iordOut(iordOut4), .busy(busy4),
        .done(done4), .sel_err(sel_err4), .align_err(align_err4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; iordmux = 3'b000; word_access = 1'b0;
        pcOut = 32'h0; aluResult = 32'h0; aluOutOut = 32'h0;
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({iordOut, busy, done, sel_err, align_err} !== {32'h0, 4'b0000}) begin
                errors++;
                $display("FAIL reset_idle cycle %0d got addr=%h flags=%b want addr=0 flags=0000",
                         i, iordOut, {busy, done, sel_err, align_err});
            end
        end
    endtask

    task automatic test_basic();
        iordmux = 3'b000; pcOut = 32'h40; word_access = 1'b0; req = 1'b1;
        step();
        req = 1'b0; pcOut = 32'h99;
        checks++;
        if ({iordOut, busy, done} !== {32'h40, 2'b10}) begin
            errors++;
            $display("FAIL basic_edge0 got addr=%h busy=%b done=%b want addr=40 busy=1 done=0",
                     iordOut, busy, done);
        end
        step();
        checks++;
        if ({iordOut, busy, done} !== {32'h40, 2'b10}) begin
            errors++;
            $display("FAIL basic_edge1 got addr=%h busy=%b done=%b want addr=40 busy=1 done=0",
                     iordOut, busy, done);
        end
        step();
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL basic_edge2 got busy=%b done=%b want busy=0 done=1", busy, done);
        end
        checks++;
        if ({busy4, done4} !== 2'b10) begin
            errors++;
            $display("FAIL wc4_still_busy got busy=%b done=%b want busy=1 done=0", busy4, done4);
        end
        step();
        checks++;
        if ({busy, done, iordOut} !== {2'b00, 32'h40}) begin
            errors++;
            $display("FAIL basic_edge3 got busy=%b done=%b addr=%h want 0 0 40", busy, done, iordOut);
        end
        step();
        checks++;
        if ({busy4, done4} !== 2'b01) begin
            errors++;
            $display("FAIL wc4_done_edge4 got busy=%b done=%b want busy=0 done=1", busy4, done4);
        end
        step();
    endtask

    task automatic test_illegal();
        iordmux = 3'b110; word_access = 1'b1; req = 1'b1;
        step();
        req = 1'b0;
        checks++;
        if ({sel_err, align_err, busy, iordOut} !== {3'b100, 32'h40}) begin
            errors++;
            $display("FAIL illegal_sel got sel=%b align=%b busy=%b addr=%h want 1 0 0 40",
                     sel_err, align_err, busy, iordOut);
        end
        step();
        checks++;
        if ({sel_err, busy} !== 2'b00) begin
            errors++;
            $display("FAIL illegal_pulse_width got sel=%b busy=%b want 0 0", sel_err, busy);
        end
        word_access = 1'b0; iordmux = 3'b001; aluResult = 32'h1234; req = 1'b1;
        step();
        iordmux = 3'b111; aluResult = 32'hDEAD;
        checks++;
        if ({iordOut, busy} !== {32'h1234, 1'b1}) begin
            errors++;
            $display("FAIL alu_accept got addr=%h busy=%b want 1234 1", iordOut, busy);
        end
        step();
        checks++;
        if ({sel_err, busy, iordOut} !== {2'b01, 32'h1234}) begin
            errors++;
            $display("FAIL req_in_wait got sel=%b busy=%b addr=%h want 0 1 1234", sel_err, busy, iordOut);
        end
        step();
        req = 1'b0;
        checks++;
        if ({sel_err, done, iordOut} !== {2'b01, 32'h1234}) begin
            errors++;
            $display("FAIL wait_ignore_done got sel=%b done=%b addr=%h want 0 1 1234", sel_err, done, iordOut);
        end
        step();
        step(); step();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  sels [3];
        logic [31:0] exp  [3];
        sels = '{3'b011, 3'b100, 3'b101};
        exp  = '{32'd253, 32'd254, 32'd255};
        word_access = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iordmux = sels[i]; req = 1'b1;
            step();
            req = 1'b0;
            checks++;
            if ({iordOut, busy, done} !== {exp[i], 2'b10}) begin
                errors++;
                $display("FAIL b2b_accept_%0d got addr=%h busy=%b done=%b want addr=%h 1 0",
                         i, iordOut, busy, done, exp[i]);
            end
            step();
            step();
            checks++;
            if ({busy, done} !== 2'b01) begin
                errors++;
                $display("FAIL b2b_done_%0d got busy=%b done=%b want 0 1", i, busy, done);
            end
        end
        step();
        checks++;
        if ({busy, done, iordOut} !== {2'b00, 32'd255}) begin
            errors++;
            $display("FAIL b2b_final got busy=%b done=%b addr=%h want 0 0 000000ff", busy, done, iordOut);
        end
        step(); step();
    endtask

    task automatic test_align();
        iordmux = 3'b010; aluOutOut = 32'h1002; word_access = 1'b1; req = 1'b1;
        step();
        req = 1'b0;
`ifdef IORD_ALIGN_CHECK_EN
        checks++;
        if ({align_err, sel_err, busy, iordOut} !== {3'b100, 32'd255}) begin
            errors++;
            $display("FAIL align_reject got align=%b sel=%b busy=%b addr=%h want 1 0 0 000000ff",
                     align_err, sel_err, busy, iordOut);
        end
        step();
        checks++;
        if ({align_err, busy} !== 2'b00) begin
            errors++;
            $display("FAIL align_pulse_width got align=%b busy=%b want 0 0", align_err, busy);
        end
        iordmux = 3'b011; req = 1'b1;
        step();
        req = 1'b0;
        checks++;
        if ({align_err, busy, iordOut} !== {2'b01, 32'd253}) begin
            errors++;
            $display("FAIL align_vector got align=%b busy=%b addr=%h want 0 1 000000fd", align_err, busy, iordOut);
        end
        step(); step(); step();
`else
        checks++;
        if ({align_err, busy, iordOut} !== {2'b01, 32'h1002}) begin
            errors++;
            $display("FAIL align_off_accept got align=%b busy=%b addr=%h want 0 1 00001002",
                     align_err, busy, iordOut);
        end
        step(); step(); step();
`endif
        iordmux = 3'b010; aluOutOut = 32'h1003; word_access = 1'b0; req = 1'b1;
        step();
        req = 1'b0;
        checks++;
        if ({align_err, busy, iordOut} !== {2'b01, 32'h1003}) begin
            errors++;
            $display("FAIL byte_unaligned got align=%b busy=%b addr=%h want 0 1 00001003",
                     align_err, busy, iordOut);
        end
        step(); step(); step();
        aluOutOut = 32'h1004; word_access = 1'b1; req = 1'b1;
        step();
        req = 1'b0; word_access = 1'b0;
        checks++;
        if ({align_err, busy, iordOut} !== {2'b01, 32'h1004}) begin
            errors++;
            $display("FAIL word_aligned got align=%b busy=%b addr=%h want 0 1 00001004",
                     align_err, busy, iordOut);
        end
        step(); step(); step(); step(); step();
    endtask

    task automatic test_reset_mid();
        int seen_done;
        iordmux = 3'b000; pcOut = 32'h80; req = 1'b1;
        step();
        req = 1'b0;
        checks++;
        if ({iordOut4, busy4} !== {32'h80, 1'b1}) begin
            errors++;
            $display("FAIL mid_start got addr=%h busy=%b want 00000080 1", iordOut4, busy4);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({iordOut4, busy4, done4, sel_err4, align_err4} !== {32'h0, 4'b0000}) begin
            errors++;
            $display("FAIL mid_reset got addr=%h flags=%b want addr=0 flags=0000",
                     iordOut4, {busy4, done4, sel_err4, align_err4});
        end
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done4 || busy4) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL mid_no_done got %0d active cycles want 0", seen_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_back_to_back();
        test_align();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
